// File: rtl/wr_pps_pkg.sv
// Shared state encoding and counter widths for the WR PPS monitor.
package wr_pps_pkg;

  localparam int PERIOD_W = 32;
  localparam int ERR_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2,
    ST_HOLDOVER = 2'd3
  } pps_state_e;

endpackage

// File: rtl/wr_sat_counter.sv
// Saturating event counter; a same-cycle clear beats an increment.
module wr_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i && (count_q != '1))
      count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/wr_pps_monitor.sv
// WR PPS consumer: period check, lock tracking, clean PPS regeneration.
// Define WR_PPS_HOLDOVER_EN to flywheel through PPS dropouts after lock.
module wr_pps_monitor
  import wr_pps_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 62500000,
  parameter int TOL_CLKS     = 16,
  parameter int LOCK_COUNT   = 3,
  parameter int HOLDOVER_MAX = 10
) (
  input  logic                clk_sys_i,
  input  logic                rst_n_i,
  input  logic                pps_i,
  input  logic                clear_i,
  output logic                pps_o,
  output logic                locked_o,
  output logic                holdover_o,
  output logic [1:0]          state_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic [PERIOD_W-1:0] pps_count_o,
  output logic [ERR_W-1:0]    missing_count_o,
  output logic [ERR_W-1:0]    glitch_count_o
);

  localparam logic [PERIOD_W-1:0] WIN_LO   = PERIOD_W'(CLK_FREQ_HZ - TOL_CLKS);
  localparam logic [PERIOD_W-1:0] WIN_HI   = PERIOD_W'(CLK_FREQ_HZ + TOL_CLKS);
  // One small counter width serves both the lock and the holdover tallies.
  localparam int SM_MAX = (LOCK_COUNT > HOLDOVER_MAX) ? LOCK_COUNT : HOLDOVER_MAX;
  localparam int SM_W   = $clog2(SM_MAX + 1);
  localparam logic [SM_W-1:0] GOOD_TGT = SM_W'(LOCK_COUNT);

  pps_state_e          state_q, state_d;
  logic                pps_d_q;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] ppscnt_q;
  logic [SM_W-1:0]     good_q, good_d, good_inc;
  logic                pulse_q, pulse_d;
  logic                miss_inc, glitch_inc;
  logic                rise, timeout, in_win;
  logic [PERIOD_W-1:0] meas;

`ifdef WR_PPS_HOLDOVER_EN
  localparam logic [PERIOD_W-1:0] HO_LOAD  = PERIOD_W'(TOL_CLKS + 1);
  localparam logic [PERIOD_W-1:0] FLY_LAST = PERIOD_W'(CLK_FREQ_HZ - 1);
  localparam logic [SM_W-1:0]     HO_TGT   = SM_W'(HOLDOVER_MAX);
  logic [SM_W-1:0] ho_q, ho_d, ho_inc;
  assign ho_inc = ho_q + SM_W'(1);
`endif

  assign rise     = pps_i & ~pps_d_q;
  assign meas     = cnt_q + PERIOD_W'(1);
  assign timeout  = (cnt_q == WIN_HI);
  assign in_win   = (meas >= WIN_LO) && (meas <= WIN_HI);
  assign good_inc = good_q + SM_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == '1) ? cnt_q : cnt_q + PERIOD_W'(1);
    good_d     = good_q;
    period_d   = period_q;
    pulse_d    = 1'b0;
    miss_inc   = 1'b0;
    glitch_inc = 1'b0;
`ifdef WR_PPS_HOLDOVER_EN
    ho_d       = ho_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
          good_d  = '0;
        end
      end
      // Timeout is tested first so a rise on the timeout cycle is dropped.
      ST_ACQUIRE: begin
        if (timeout) begin
          state_d  = ST_IDLE;
          miss_inc = 1'b1;
        end else if (rise) begin
          period_d = meas;
          cnt_d    = '0;
          if (in_win) begin
            good_d = good_inc;
            if (good_inc >= GOOD_TGT) begin
              state_d = ST_LOCKED;
              pulse_d = 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (timeout) begin
          miss_inc = 1'b1;
`ifdef WR_PPS_HOLDOVER_EN
          // Reload so the flywheel wraps on the nominal edge positions.
          state_d = ST_HOLDOVER;
          cnt_d   = HO_LOAD;
          ho_d    = '0;
`else
          state_d = ST_IDLE;
`endif
        end else if (rise) begin
          if (in_win) begin
            pulse_d  = 1'b1;
            period_d = meas;
            cnt_d    = '0;
          end else begin
            glitch_inc = 1'b1;
          end
        end
      end
`ifdef WR_PPS_HOLDOVER_EN
      ST_HOLDOVER: begin
        if (rise) begin
          state_d = ST_ACQUIRE;
          cnt_d   = '0;
          good_d  = '0;
        end else if (cnt_q == FLY_LAST) begin
          cnt_d   = '0;
          pulse_d = 1'b1;
          ho_d    = ho_inc;
          if (ho_inc >= HO_TGT) state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      pps_d_q  <= 1'b0;
      cnt_q    <= '0;
      good_q   <= '0;
      period_q <= '0;
      pulse_q  <= 1'b0;
      ppscnt_q <= '0;
`ifdef WR_PPS_HOLDOVER_EN
      ho_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pps_d_q  <= pps_i;
      cnt_q    <= cnt_d;
      good_q   <= good_d;
      period_q <= period_d;
      pulse_q  <= pulse_d;
`ifdef WR_PPS_HOLDOVER_EN
      ho_q     <= ho_d;
`endif
      if (clear_i)      ppscnt_q <= '0;
      else if (pulse_d) ppscnt_q <= ppscnt_q + PERIOD_W'(1);
    end
  end

  wr_sat_counter #(.WIDTH(ERR_W)) u_missing (
    .clk_i   (clk_sys_i),
    .rst_n_i (rst_n_i),
    .inc_i   (miss_inc),
    .clr_i   (clear_i),
    .count_o (missing_count_o)
  );

  wr_sat_counter #(.WIDTH(ERR_W)) u_glitch (
    .clk_i   (clk_sys_i),
    .rst_n_i (rst_n_i),
    .inc_i   (glitch_inc),
    .clr_i   (clear_i),
    .count_o (glitch_count_o)
  );

  assign pps_o       = pulse_q;
  assign state_o     = state_q;
  assign locked_o    = (state_q == ST_LOCKED);
`ifdef WR_PPS_HOLDOVER_EN
  assign holdover_o  = (state_q == ST_HOLDOVER);
`else
  assign holdover_o  = 1'b0;
`endif
  assign period_o    = period_q;
  assign pps_count_o = ppscnt_q;

endmodule
